// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// regfile_wb_arbiter_if : write-back requester / register-file bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             hold;
  logic             a_valid;
  logic [4:0]       a_rd;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [4:0]       b_rd;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             rf_write_enable;
  logic [4:0]       rf_dest;
  logic [WIDTH-1:0] rf_data;
  logic [4:0]       q_rd;
  logic             q_hit;
  logic [WIDTH-1:0] q_data;

  modport master (
    output hold, a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rd,
    input  a_ready, b_ready, rf_write_enable, rf_dest, rf_data, q_hit, q_data
  );

  modport slave (
    input  hold, a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rd,
    output a_ready, b_ready, rf_write_enable, rf_dest, rf_data, q_hit, q_data
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : fixed-priority write-port arbiter with starvation guard
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input wire logic             clk,
  input wire logic             reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_dest_q, rf_dest_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;

  logic w_force_b, w_a_ready, w_b_ready, w_grant_a, w_grant_b;

  // Readies depend only on hold/valids so requesters see no data-path loop.
  always_comb begin
    w_force_b = (starve_cnt_q == C_STARVE_LIMIT);
    w_a_ready = !bus.hold && !(w_force_b && bus.b_valid);
    w_grant_a = bus.a_valid && w_a_ready;
    w_b_ready = !bus.hold && !w_grant_a;
    w_grant_b = bus.b_valid && w_b_ready;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.hold) begin
      if (w_grant_b || !bus.b_valid) begin
        starve_cnt_d = 4'd0;
      end else if (starve_cnt_q != C_STARVE_LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Writes to r0 complete the handshake but never reach the register file.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_data_d = rf_data_q;
    if (w_grant_a) begin
      rf_we_d   = (bus.a_rd != 5'd0);
      rf_dest_d = bus.a_rd;
      rf_data_d = bus.a_data;
    end else if (w_grant_b) begin
      rf_we_d   = (bus.b_rd != 5'd0);
      rf_dest_d = bus.b_rd;
      rf_data_d = bus.b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_dest_q    <= 5'd0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_dest_q    <= rf_dest_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign bus.a_ready         = w_a_ready;
  assign bus.b_ready         = w_b_ready;
  assign bus.rf_write_enable = rf_we_q;
  assign bus.rf_dest         = rf_dest_q;
  assign bus.rf_data         = rf_data_q;
  assign bus.q_hit           = rf_we_q && (rf_dest_q == bus.q_rd);
  assign bus.q_data          = rf_data_q;
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : scoreboard bench with directed and random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  regfile_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  regfile_wb_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: consecutive B denials and the last accepted write.
  int          denied = 0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_dest = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        last_ar, last_br;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one, on time.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missing_write_rd", 32'(bus.rf_dest), 32'(exp_q[0].rd) | 32'h100);
        void'(exp_q.pop_front());
      end
      if (bus.rf_write_enable === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          chk("unexpected_write", 32'(bus.rf_write_enable), 32'd0);
        end else begin
          chk("wr_dest", 32'(bus.rf_dest), 32'(exp_q[0].rd));
          chk("wr_data", bus.rf_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic h, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic bv, input logic [4:0] brd,
                      input logic [31:0] bd, input logic [4:0] qr, input logic rn);
    logic b_first, exp_ar, exp_br, ga, gb;
    @(negedge clk);
    bus.hold = h;  bus.q_rd = qr;  reset = rn;
    bus.a_valid = av;  bus.a_rd = ard;  bus.a_data = ad;
    bus.b_valid = bv;  bus.b_rd = brd;  bus.b_data = bd;
    #1;
    // B goes first once it has been turned away LIMIT non-stalled cycles in a row.
    b_first = (denied >= LIMIT) && bv;
    exp_ar  = !h && !b_first;
    ga      = av && exp_ar;
    exp_br  = !h && !ga;
    gb      = bv && exp_br;
    last_ar = exp_ar;
    last_br = exp_br;
    chk("a_ready", 32'(bus.a_ready), 32'(exp_ar));
    chk("b_ready", 32'(bus.b_ready), 32'(exp_br));
    chk("rf_we", 32'(bus.rf_write_enable), 32'(m_we));
    chk("q_hit", 32'(bus.q_hit), 32'(m_we && (m_dest == qr) && (qr != 5'd0)));
    chk("q_data", bus.q_data, m_data);
    if (!rn) begin
      denied = 0;  m_we = 1'b0;  m_dest = 5'd0;  m_data = 32'd0;
    end else begin
      if (!h) denied = (gb || !bv) ? 0 : ((denied + 1 > LIMIT) ? LIMIT : denied + 1);
      if (ga || gb) begin
        m_dest = ga ? ard : brd;
        m_data = ga ? ad : bd;
        m_we   = (m_dest != 5'd0);
        if (m_we) exp_q.push_back('{cyc: cyc + 1, rd: m_dest, data: m_data});
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  initial begin
    logic        h, av, bv, rn, a_pend, b_pend;
    logic [4:0]  ard, brd, qr;
    logic [31:0] ad, bd;
    reset = 1'b0;
    bus.hold = 1'b0;  bus.a_valid = 1'b0;  bus.b_valid = 1'b0;
    bus.a_rd = 5'd0;  bus.b_rd = 5'd0;  bus.a_data = '0;  bus.b_data = '0;  bus.q_rd = 5'd0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 1);
    // A only
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 5, 1);
    step(0, 0, 0, 0, 0, 0, 0, 5, 1);
    // Conflict with starvation: B forced through after LIMIT denials
    for (int i = 0; i < 8; i++) step(0, 1, 3, 32'h100 + i, 1, 7, 32'h1234, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Hold mid-conflict
    for (int i = 0; i < 2; i++) step(0, 1, 4, 32'h200 + i, 1, 7, 32'h1234, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 4, 32'h202, 1, 7, 32'h1234, 4, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 4, 32'h210 + i, 1, 7, 32'h1234, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // rd=0 discard
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Forwarding query
    step(0, 0, 0, 0, 1, 12, 32'hCAFE0001, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 12, 1);
    step(0, 0, 0, 0, 0, 0, 0, 13, 1);
    // Reset while a write is registered
    step(0, 1, 9, 32'h99, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 1);

    // Random traffic; a requester keeps rd/data stable while stalled
    a_pend = 0;  b_pend = 0;
    ard = 0;  ad = 0;  brd = 0;  bd = 0;
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      h  = ($urandom_range(0, 4) == 0);
      av = a_pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      bv = b_pend ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (!a_pend) begin ard = 5'($urandom); ad = $urandom; end
      if (!b_pend) begin brd = 5'($urandom); bd = $urandom; end
      qr = ($urandom_range(0, 1) == 0) ? m_dest : 5'($urandom);
      step(h, av, ard, ad, bv, brd, bd, qr, rn);
      a_pend = rn && av && !last_ar;
      b_pend = rn && bv && !last_br;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32-entry register file's single write port. Shares the port between two requesters: A, the main pipeline write-back, and B, the multi-cycle unit (divider/load return). It uses fixed priority for A with a starvation guard for B. Accepted writes are registered for one cycle before they drive the register file. The registered stage is exposed as a pending-write query, so hazard logic can forward the value.

## Interface
- WIDTH, 32, data width of requesters and register file
- STARVE_LIMIT, 4, consecutive denied B cycles before B is forced ahead of A (range 1..15)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- hold  in  1  global stall; when 1, no request is accepted
- a_valid  in  1  requester A has a write
- a_rd  in  5  requester A destination register
- a_data  in  WIDTH  requester A write data
- a_ready  out  1  requester A write accepted this cycle when a_valid=1
- b_valid  in  1  requester B has a write
- b_rd  in  5  requester B destination register
- b_data  in  WIDTH  requester B write data
- b_ready  out  1  requester B write accepted this cycle when b_valid=1
- rf_write_enable  out  1  register-file write enable (registered)
- rf_dest  out  5  register-file destination select (registered)
- rf_data  out  WIDTH  register-file write data (registered)
- q_rd  in  5  pending-write query register index
- q_hit  out  1  combinational: a registered write to q_rd is in flight
- q_data  out  WIDTH  combinational: equals rf_data

## Operation
- Starve counter starve_cnt (4 bits) defines force_b = (starve_cnt == STARVE_LIMIT).
- a_ready = !hold && !(force_b && b_valid).
- grant_a = a_valid && a_ready.
- b_ready = !hold && !grant_a.
- grant_b = b_valid && b_ready.
- A and B are never granted in the same cycle.
- A valid/ready handshake completes when valid && ready is 1 at a rising edge.
- A requester holds its rd and data stable while valid=1 and ready=0.
- starve_cnt update, first matching rule wins:
  - reset → 0
  - hold=1 → unchanged
  - grant_b or b_valid=0 → 0
  - otherwise, b_valid && !grant_b → +1, saturating at STARVE_LIMIT
- Write register update, at the edge after a grant:
  - rf_write_enable ← 1 if the granted rd ≠ 0, else 0
  - rf_dest ← granted rd
  - rf_data ← granted data
- A handshake with rd=0 completes normally, but the write is discarded: rf_write_enable stays 0.
- No grant (including hold=1) → rf_write_enable ← 0; rf_dest and rf_data retain their values.
- q_hit = rf_write_enable && (rf_dest == q_rd); q_rd=0 always gives q_hit=0.
- Reset values: rf_write_enable=0, rf_dest=0, rf_data=0, starve_cnt=0.
- a_ready and b_ready are combinational. During reset they follow the formulas; requesters ignore them while reset=0.
- Reset asserted while a write is registered: the write is dropped; rf_write_enable is 0 after that edge.

## Timing
- Latency: grant at edge N → rf_write_enable/rf_dest/rf_data valid during cycle N+1 → register file captures within cycle N+1.
- Throughput: one write per cycle, sustained.
- B worst-case wait under continuous A traffic: STARVE_LIMIT cycles denied, then granted on cycle STARVE_LIMIT+1.
- Cycles with hold=1 are excluded from this count.
- A is never blocked two consecutive cycles by force_b, because starve_cnt clears on grant_b.
- The ready outputs depend combinationally on hold, a_valid and b_valid only. There is no path from a_rd, b_rd, a_data or b_data to the ready outputs.
- q_hit/q_data are combinational from registered state and q_rd, so decode may use them in the same cycle.

## Test plan
- A only: a_valid=1, a_rd=5, a_data=32'hDEADBEEF, no hold → a_ready=1 → next cycle rf_write_enable=1, rf_dest=5, rf_data=32'hDEADBEEF; following cycle rf_write_enable=0.
- Conflict with starvation, STARVE_LIMIT=4: a_valid=1 and b_valid=1 every cycle (b_rd=7, b_data=32'h1234) → A granted cycles 0–3; cycle 4 b_ready=1, a_ready=0 with rf_dest=7 on cycle 5; then A granted again with starve_cnt=0.
- Hold mid-conflict: same traffic, hold=1 for 3 cycles after 2 denials → a_ready=b_ready=0 and rf_write_enable=0 during hold; starve_cnt stays 2; B granted 2 cycles after hold releases.
- rd=0 discard: a_rd=0, a_data=32'hFFFFFFFF, a_valid=1 → a_ready=1; next cycle rf_write_enable=0 and q_hit=0 for q_rd=0.
- Forwarding query: B write rd=12, data=32'hCAFE0001 granted → next cycle q_rd=12 gives q_hit=1, q_data=32'hCAFE0001; q_rd=13 gives q_hit=0.
- Reset mid-operation: write to rd=9 granted, reset=0 sampled on the next edge → rf_write_enable=0, rf_dest=0, rf_data=0, starve_cnt=0.
